switch_press_decoder: RTL and testbench



---
 rtl/switch_press_decoder.sv | 129 ++++++++++++
 tb/tb_switch_press_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_press_decoder.sv
// Classifies debounced switch gestures as short, long or double press.
// Optional LED toggle on short/double, cleared on long: PRESS_LED_TOGGLE_EN.
module switch_press_decoder #(
  parameter int c_LONG_LIMIT = 12500000,
  parameter int c_GAP_LIMIT  = 6250000,
  parameter int CNT_WIDTH    = 24
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_Switch,
  output logic o_Short,
  output logic o_Long,
  output logic o_Double,
  output logic o_Busy,
  output logic o_LED
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    GAP,
    PRESS2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_LONG_LAST =
    CNT_WIDTH'(c_LONG_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] c_GAP_LAST =
    CNT_WIDTH'(c_GAP_LIMIT - 1);

  state_t               r_State;
  state_t               w_Next;
  logic                 r_Prev;
  logic [CNT_WIDTH-1:0] r_Cnt;
  logic [CNT_WIDTH-1:0] w_CntNext;
  logic                 w_Rise;
  logic                 w_Fall;
  logic                 w_Short;
  logic                 w_Long;
  logic                 w_Double;

  assign w_Rise = i_Switch & ~r_Prev;
  assign w_Fall = ~i_Switch & r_Prev;

  always_comb begin
    w_Next   = r_State;
    w_Short  = 1'b0;
    w_Long   = 1'b0;
    w_Double = 1'b0;
    unique case (r_State)
      IDLE: begin
        if (w_Rise) w_Next = PRESS1;
      end
      PRESS1: begin
        // release beats the long limit on the same edge
        if (w_Fall) begin
          w_Next = GAP;
        end else if (r_Cnt == c_LONG_LAST) begin
          w_Next = LONG_HELD;
          w_Long = 1'b1;
        end
      end
      LONG_HELD: begin
        if (w_Fall) w_Next = IDLE;
      end
      GAP: begin
        if (w_Rise) begin
          w_Next = PRESS2;
        end else if (r_Cnt == c_GAP_LAST) begin
          w_Next  = IDLE;
          w_Short = 1'b1;
        end
      end
      PRESS2: begin
        if (w_Fall) begin
          w_Next   = IDLE;
          w_Double = 1'b1;
        end
      end
      default: w_Next = IDLE;
    endcase
  end

  always_comb begin
    w_CntNext = r_Cnt;
    if (w_Next != r_State)
      w_CntNext = '0;
    else if (r_State == PRESS1 || r_State == GAP)
      w_CntNext = r_Cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_State  <= IDLE;
      r_Prev   <= 1'b0;
      r_Cnt    <= '0;
      o_Short  <= 1'b0;
      o_Long   <= 1'b0;
      o_Double <= 1'b0;
    end else begin
      r_State  <= w_Next;
      r_Prev   <= i_Switch;
      r_Cnt    <= w_CntNext;
      o_Short  <= w_Short;
      o_Long   <= w_Long;
      o_Double <= w_Double;
    end
  end

  assign o_Busy = (r_State != IDLE);

`ifdef PRESS_LED_TOGGLE_EN
  logic r_LED;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_LED <= 1'b0;
    else if (w_Long)
      r_LED <= 1'b0;
    else if (w_Short || w_Double)
      r_LED <= ~r_LED;
  end

  assign o_LED = r_LED;
`else
  assign o_LED = 1'b0;
`endif

endmodule

// File: tb/tb_switch_press_decoder.sv
// Bench for switch_press_decoder: directed gestures plus random levels
// checked against a timestamp-based gesture model.
module tb_switch_press_decoder;

  localparam int L = 20;
  localparam int G = 10;

  logic CLK;
  logic RST_N;
  logic i_Switch;
  logic o_Short;
  logic o_Long;
  logic o_Double;
  logic o_Busy;
  logic o_LED;

  int n_chk;
  int n_fail;

  // model state
  int   m_mode;
  int   m_t0;
  int   m_n;
  logic m_prev;
  logic e_s;
  logic e_l;
  logic e_d;
  logic e_led;

  switch_press_decoder #(
    .c_LONG_LIMIT(L),
    .c_GAP_LIMIT (G),
    .CNT_WIDTH   (5)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_Switch(i_Switch),
    .o_Short (o_Short),
    .o_Long  (o_Long),
    .o_Double(o_Double),
    .o_Busy  (o_Busy),
    .o_LED   (o_LED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [4:0] exp_v();
    return {e_s, e_l, e_d, (m_mode != 0), e_led};
  endfunction

  function automatic logic [4:0] got_v();
    return {o_Short, o_Long, o_Double, o_Busy, o_LED};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_prev = 1'b0;
    e_s    = 1'b0;
    e_l    = 1'b0;
    e_d    = 1'b0;
    e_led  = 1'b0;
  endtask

  // Gesture rules by elapsed edges since the last press/release.
  task automatic model_edge(input logic sw);
    bit rise;
    bit fall;
    m_n++;
    e_s = 1'b0;
    e_l = 1'b0;
    e_d = 1'b0;
    if (!RST_N) begin
      model_reset();
      return;
    end
    rise = sw && !m_prev;
    fall = !sw && m_prev;
    m_prev = sw;
    case (m_mode)
      0: if (rise) begin m_mode = 1; m_t0 = m_n; end
      1: begin
        if (fall) begin
          m_mode = 2; m_t0 = m_n;
        end else if (m_n - m_t0 == L) begin
          m_mode = 3; e_l = 1'b1;
        end
      end
      3: if (fall) m_mode = 0;
      2: begin
        if (rise) m_mode = 4;
        else if (m_n - m_t0 == G) begin
          m_mode = 0; e_s = 1'b1;
        end
      end
      default: if (fall) begin m_mode = 0; e_d = 1'b1; end
    endcase
`ifdef PRESS_LED_TOGGLE_EN
    if (e_l) e_led = 1'b0;
    else if (e_s || e_d) e_led = ~e_led;
`endif
  endtask

  task automatic tick(input logic sw);
    @(negedge CLK);
    i_Switch = sw;
    @(posedge CLK);
    model_edge(sw);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    i_Switch = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if (got_v() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset got=%b want=%b", got_v(), 5'b0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_short();
    int ns = 0;
    int nx = 0;
    int at = -1;
    int rel;
    repeat (5) tick(1'b1);
    tick(1'b0);
    rel = m_n;
    repeat (15) begin
      tick(1'b0);
      if (o_Short) begin ns++; at = m_n - rel; end
      if (o_Long || o_Double) nx++;
      n_chk++;
      if (got_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL short n=%0d got=%b want=%b",
                 m_n, got_v(), exp_v());
      end
    end
    n_chk++;
    if (ns != 1 || at != G || nx != 0 || o_Busy) begin
      n_fail++;
      $display("FAIL short_once got=%0d@%0d other=%0d want=1@%0d 0",
               ns, at, nx, G);
    end
  endtask

  task automatic test_long();
    int nl = 0;
    int at = -1;
    int cap;
    tick(1'b1);
    cap = m_n;
    repeat (29) begin
      tick(1'b1);
      if (o_Long) begin nl++; at = m_n - cap; end
      n_chk++;
      if (got_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL long n=%0d got=%b want=%b",
                 m_n, got_v(), exp_v());
      end
    end
    repeat (12) begin
      tick(1'b0);
      if (o_Short || o_Long || o_Double) nl++;
    end
    n_chk++;
    if (nl != 1 || at != L || o_Busy) begin
      n_fail++;
      $display("FAIL long_once got=%0d@%0d busy=%b want=1@%0d",
               nl, at, o_Busy, L);
    end
  endtask

  task automatic test_double();
    int nd = 0;
    int ns = 0;
    logic [0:0] pat [$];
    pat = {1,1,1,1,0,0,0,1,1,1,1};
    repeat (12) pat.push_back(1'b0);
    foreach (pat[i]) begin
      tick(pat[i]);
      nd += int'(o_Double);
      ns += int'(o_Short || o_Long);
      n_chk++;
      if (got_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL double n=%0d got=%b want=%b",
                 m_n, got_v(), exp_v());
      end
    end
    n_chk++;
    if (nd != 1 || ns != 0) begin
      n_fail++;
      $display("FAIL double_once got=%0d/%0d want=1/0", nd, ns);
    end
  endtask

  task automatic test_boundary();
    int ns = 0;
    int nl = 0;
    int nd = 0;
    // release on the L-th held edge
    repeat (L) tick(1'b1);
    tick(1'b0);
    repeat (G + 3) begin
      tick(1'b0);
      ns += int'(o_Short);
      nl += int'(o_Long);
      nd += int'(o_Double);
    end
    n_chk++;
    if (ns != 1 || nl != 0 || nd != 0) begin
      n_fail++;
      $display("FAIL edge_long s/l/d=%0d/%0d/%0d want 1/0/0",
               ns, nl, nd);
    end
    ns = 0;
    nd = 0;
    // second press on the G-th gap edge
    repeat (3) tick(1'b1);
    tick(1'b0);
    repeat (G - 1) begin
      tick(1'b0);
      ns += int'(o_Short);
    end
    tick(1'b1);
    ns += int'(o_Short);
    tick(1'b1);
    tick(1'b0);
    nd += int'(o_Double);
    repeat (G + 3) begin
      tick(1'b0);
      ns += int'(o_Short);
      nd += int'(o_Double);
    end
    n_chk++;
    if (ns != 0 || nd != 1) begin
      n_fail++;
      $display("FAIL edge_gap s/d=%0d/%0d want 0/1", ns, nd);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      repeat (4) tick(1'b1);
      if (k == 1) repeat (3) tick(1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      n_chk++;
      if (got_v() !== 5'b0) begin
        n_fail++;
        $display("FAIL async_rst k=%0d got=%b want=%b",
                 k, got_v(), 5'b0);
      end
      tick(1'b0);
      tick(1'b0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (G + L) begin
        tick(1'b0);
        n_chk++;
        if (got_v() !== 5'b0) begin
          n_fail++;
          $display("FAIL post_rst k=%0d got=%b want=%b",
                   k, got_v(), 5'b0);
        end
      end
    end
  endtask

  task automatic test_led();
    logic [2:0] seen;
    logic [2:0] want;
`ifdef PRESS_LED_TOGGLE_EN
    want = 3'b100;
`else
    want = 3'b000;
`endif
    repeat (5) tick(1'b1);
    repeat (15) tick(1'b0);
    seen[2] = o_LED;
    repeat (4) tick(1'b1);
    repeat (3) tick(1'b0);
    repeat (4) tick(1'b1);
    repeat (12) tick(1'b0);
    seen[1] = o_LED;
    repeat (30) tick(1'b1);
    repeat (5) tick(1'b0);
    seen[0] = o_LED;
    n_chk++;
    if (seen !== want) begin
      n_fail++;
      $display("FAIL led_seq got=%b want=%b", seen, want);
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int   len;
    int   npulse;
    for (int s = 0; s < 60; s++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 25);
      repeat (len) begin
        tick(lvl);
        npulse = int'(o_Short) + int'(o_Long) + int'(o_Double);
        n_chk++;
        if (got_v() !== exp_v() || npulse > 1) begin
          n_fail++;
          $display("FAIL random n=%0d got=%b want=%b",
                   m_n, got_v(), exp_v());
        end
      end
    end
    repeat (L + G) tick(1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_n    = 0;
    m_t0   = 0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundary();
    test_async_reset();
    test_led();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
